zap_decode_sched: RTL

ZAP_DECODE_SCHED -- requirements
Module: zap_decode_sched

---
 rtl/zap_decode_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/zap_decode_sched.sv
// rtl/zap_decode_sched.sv - two-entry fetch-to-decode queue with stall/flush resolution and interrupt injection
module zap_decode_sched #(
  parameter int INSTR_W = 36
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic               i_instruction_valid,
  input  logic [31:0]        i_pc_ff,
  output logic               o_fetch_stall,
  input  logic               i_code_stall,
  input  logic               i_clear_from_writeback,
  input  logic               i_data_stall,
  input  logic               i_clear_from_alu,
  input  logic               i_stall_from_shifter,
  input  logic               i_stall_from_issue,
  input  logic               i_irq,
  input  logic               i_fiq,
  input  logic               i_cpsr_ff_i,
  input  logic               i_cpsr_ff_f,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instruction_valid,
  output logic [31:0]        o_pc_ff,
  output logic               o_irq,
  output logic               o_fiq,
  output logic               o_flush,
  output logic               o_hold
);

  typedef enum logic [1:0] {IDLE, INJECT, WAIT} state_t;

  state_t             state;
  logic [INSTR_W-1:0] instr_mem [2];
  logic [31:0]        pc_mem    [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               fiq_q;
  logic               irq_q;

  logic flush;
  logic hold;
  logic push;
  logic pop;
  logic pend_fiq;
  logic pend_irq;

  // An ALU clear is only honoured once the data side is no longer stalled.
  assign flush    = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall);
  assign hold     = ~flush & (i_code_stall | i_data_stall | i_stall_from_shifter | i_stall_from_issue);
  assign o_flush  = flush;
  assign o_hold   = hold;

  assign pend_fiq = i_fiq & ~i_cpsr_ff_f;
  assign pend_irq = i_irq & ~i_cpsr_ff_i;

  assign o_fetch_stall       = (count == 2'd2);
  assign o_instruction_valid = (count != 2'd0) && (state != WAIT);
  assign o_instruction       = instr_mem[rd_ptr];
  assign o_pc_ff             = pc_mem[rd_ptr];
  assign o_fiq               = fiq_q;
  assign o_irq               = irq_q;

  assign push = i_instruction_valid & ~o_fetch_stall & ~flush;
  assign pop  = o_instruction_valid & ~hold & ~flush;

  // Storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= i_instruction;
      pc_mem[wr_ptr]    <= i_pc_ff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The interrupt tag is latched on entry to INJECT so it cannot drop before the tagged word leaves.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      fiq_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((pend_fiq | pend_irq) && (count != 2'd0) && !flush) begin
            state <= INJECT;
            fiq_q <= pend_fiq;
            irq_q <= ~pend_fiq & pend_irq;
          end
        end
        INJECT: begin
          if (flush) begin
            state <= IDLE;
            fiq_q <= 1'b0;
            irq_q <= 1'b0;
          end else if (pop) begin
            state <= WAIT;
            fiq_q <= 1'b0;
            irq_q <= 1'b0;
          end
        end
        WAIT: begin
          if (i_clear_from_writeback) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          fiq_q <= 1'b0;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
